// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, angle/gain constants, FSM states.
// Angles are 32-bit binary angles where 2^31 is 180 degrees.
package cordic_pkg;

  localparam logic [31:0] ANGLE_90 = 32'h4000_0000;
  localparam int GAIN_INV_Q15 = 19898;

  localparam logic [31:0] ATAN [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    COMP,
    DONE
  } state_t;

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational micro-rotation index to arctangent lookup.
// Shared by the rotation and vectoring CORDIC cores.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 32
) (
  input  logic [4:0]         idx,
  output logic [ANGLE_W-1:0] angle
);

  assign angle = ANGLE_W'(ATAN[idx] >> (32 - ANGLE_W));

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (x, y) -> magnitude and atan2 phase.
// Define CORDIC_GAIN_COMP_EN to scale magnitude by 1/K in an extra COMP state.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ANGLE_W = 32,
  parameter int ITER    = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH:0]          magnitude,
  output logic [ANGLE_W-1:0]      phase
);

  localparam int XW = WIDTH + 2;
  localparam logic [ANGLE_W-1:0] A90 =
    ANGLE_W'(ANGLE_90 >> (32 - ANGLE_W));
  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t state;
  logic signed [XW-1:0] x, y, xe, ye;
  logic signed [XW-1:0] px, py, xn, yn;
  logic [ANGLE_W-1:0] z, pz, zn, step;
  logic [4:0] iter;
  logic zero;

  assign xe = XW'(x_in);
  assign ye = XW'(y_in);

  cordic_atan_lut #(.ANGLE_W(ANGLE_W)) u_lut (
    .idx  (iter),
    .angle(step)
  );

  // Fold the left half-plane into the right so the iterations converge
  always_comb begin
    px = xe;
    py = ye;
    pz = '0;
    if (x_in[WIDTH-1]) begin
      if (!y_in[WIDTH-1]) begin
        px = ye;
        py = -xe;
        pz = A90;
      end else begin
        px = -ye;
        py = xe;
        pz = -A90;
      end
    end
  end

  always_comb begin
    if (!y[XW-1]) begin
      xn = x + (y >>> iter);
      yn = y - (x >>> iter);
      zn = z + step;
    end else begin
      xn = x - (y >>> iter);
      yn = y + (x >>> iter);
      zn = z - step;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = XW + 16;
  logic signed [PW-1:0] prod;
  assign prod = PW'(x) * PW'(GAIN_INV_Q15) + PW'(1 << 14);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      magnitude <= '0;
      phase     <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x        <= px;
            y        <= py;
            z        <= pz;
            iter     <= '0;
            zero     <= (x_in == '0) && (y_in == '0);
            in_ready <= 1'b0;
            state    <= ROTATE;
          end
        end
        ROTATE: begin
          x    <= xn;
          y    <= yn;
          z    <= zn;
          iter <= iter + 5'd1;
          if (iter == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= COMP;
`else
            state     <= DONE;
            out_valid <= 1'b1;
            magnitude <= zero ? '0 : (WIDTH+1)'(xn);
            phase     <= zero ? '0 : zn;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          state     <= DONE;
          out_valid <= 1'b1;
          magnitude <= zero ? '0 : (WIDTH+1)'(prod >>> 15);
          phase     <= zero ? '0 : z;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: real-valued atan2/hypot model plus directed checks.
// Build with CORDIC_GAIN_COMP_EN to check the compensated magnitude.
module tb_cordic_vectoring;

  localparam int WIDTH = 16;
  localparam int ANGLE_W = 32;
  localparam int ITER = 16;
  localparam real C = 2147483648.0 / 3.141592653589793;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int COMP = 1;
  localparam int M1 = 16384, T1 = 2;
  localparam int M2 = 23170, T2 = 3;
  localparam int M3 = 11585, T3 = 3;
`else
  localparam int COMP = 0;
  localparam int M1 = 26981, T1 = 4;
  localparam int M2 = 38156, T2 = 6;
  localparam int M3 = 19078, T3 = 6;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [WIDTH-1:0] x_in = '0;
  logic signed [WIDTH-1:0] y_in = '0;
  logic in_ready, out_valid;
  logic [WIDTH:0] magnitude;
  logic [ANGLE_W-1:0] phase;

  cordic_vectoring #(
    .WIDTH(WIDTH), .ANGLE_W(ANGLE_W), .ITER(ITER)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .magnitude(magnitude), .phase(phase)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  real kg = 1.0;

  typedef struct { int x; int y; } vec_t;
  vec_t q[$];

  task automatic chk(bit ok, string name, longint act, longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  function automatic real exp_mag(int x, int y);
    real r;
    r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * kg;
    if (COMP != 0) r = r * 19898.0 / 32768.0;
    return r;
  endfunction

  function automatic longint exp_ph(int x, int y);
    if (x == 0 && y == 0) return 0;
    return longint'($atan2(real'(y), real'(x)) * C);
  endfunction

  // Angle distance modulo 2^32, so +180 and -180 compare equal
  function automatic longint ph_err(logic [31:0] p, longint e);
    logic [31:0] d;
    longint s;
    d = p - 32'(e);
    s = longint'($signed(d));
    return (s < 0) ? -s : s;
  endfunction

  // Expected-result queue: push on accept, pop on result handshake
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) q.delete();
    else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready)
        q.push_back('{x: int'(x_in), y: int'(y_in)});
    end
  end

  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (q.size() == 0) chk(1'b0, "spurious_out_valid", 1, 0);
      else begin
        real em, dm, r, pt;
        longint ep;
        int vx, vy;
        vx = q[0].x;
        vy = q[0].y;
        ep = exp_ph(vx, vy);
        if (vx == 0 && vy == 0) begin
          chk(magnitude == 0, "model_mag_zero", longint'(magnitude), 0);
          chk(phase == 0, "model_ph_zero", longint'(phase), 0);
        end else begin
          em = exp_mag(vx, vy);
          dm = real'(magnitude) - em;
          if (dm < 0) dm = -dm;
          chk(dm <= real'(ITER + 4), "model_mag",
              longint'(magnitude), longint'(em));
          r = $sqrt(real'(vx) * real'(vx) + real'(vy) * real'(vy));
          pt = 65536.0 + C * real'(ITER + 2) / (kg * r);
          chk(real'(ph_err(phase, ep)) <= pt, "model_ph",
              longint'(phase), ep & 64'hFFFF_FFFF);
        end
      end
    end
  end

  task automatic send(int x, int y);
    int n;
    @(negedge clock);
    in_valid = 1'b1;
    x_in = WIDTH'(x);
    y_in = WIDTH'(y);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk(1'b0, "accept_timeout", 0, 1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic get(string nm, int hold, output int lat,
                     output logic [WIDTH:0] m, output logic [31:0] p);
    // lat counts edges including the accepting edge
    lat = 1;
    m = '0;
    p = '0;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (!out_valid) begin
      chk(1'b0, {nm, "_result_timeout"}, lat, ITER + 1 + COMP);
      return;
    end
    m = magnitude;
    p = phase;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk(out_valid == 1'b1, {nm, "_hold_valid"}, out_valid, 1);
      chk(magnitude == m, {nm, "_hold_mag"}, magnitude, m);
      chk(phase == p, {nm, "_hold_ph"}, phase, p);
      chk(in_ready == 1'b0, {nm, "_hold_ready"}, in_ready, 0);
    end
    @(negedge clock);
    chk(in_ready == 1'b0, {nm, "_busy_ready"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    @(negedge clock);
    chk(in_ready == 1'b1, {nm, "_reaccept"}, in_ready, 1);
    chk(out_valid == 1'b0, {nm, "_valid_drop"}, out_valid, 0);
  endtask

  task automatic directed(string nm, int x, int y, int hold,
                          int m_exp, int m_tol, longint p_exp);
    int lat;
    logic [WIDTH:0] m;
    logic [31:0] p;
    int d;
    send(x, y);
    get(nm, hold, lat, m, p);
    chk(lat == ITER + 1 + COMP, {nm, "_latency"}, lat, ITER + 1 + COMP);
    d = int'(m) - m_exp;
    if (d < 0) d = -d;
    chk(d <= m_tol, {nm, "_mag"}, m, m_exp);
    chk(ph_err(p, p_exp) <= ((m_exp == 0) ? 0 : 65536),
        {nm, "_ph"}, p, p_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rx, ry;
    logic [WIDTH:0] m;
    logic [31:0] p;
    for (int i = 0; i < ITER; i++)
      kg = kg * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    repeat (2) @(negedge clock);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(magnitude == 0, "rst_mag", magnitude, 0);
    chk(phase == 0, "rst_ph", phase, 0);
    reset_n = 1'b1;

    directed("pos_x", 16384, 0, 0, M1, T1, 0);
    directed("pos_y", 0, 16384, 0, M1, T1, 64'h4000_0000);
    directed("q3", -16384, -16384, 0, M2, T2, 64'hA000_0000);
    directed("neg_x", -16384, 0, 0, M1, T1, 64'h8000_0000);
    directed("zero", 0, 0, 0, 0, 0, 0);
    directed("stall", 16384, 0, 5, M1, T1, 0);

    send(-32768, -32768);
    get("edge_a", 1, lat, m, p);
    send(-32768, 0);
    get("edge_b", 0, lat, m, p);
    send(32767, -32768);
    get("edge_c", 2, lat, m, p);

    for (int i = 0; i < 40; i++) begin
      do begin
        rx = int'($urandom_range(0, 65535)) - 32768;
        ry = int'($urandom_range(0, 65535)) - 32768;
      end while ((rx < 0 ? -rx : rx) + (ry < 0 ? -ry : ry) < 1024);
      send(rx, ry);
      get("rand", int'($urandom_range(0, 3)), lat, m, p);
    end

    send(12345, -2000);
    repeat (7) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "abort_valid", out_valid, 0);
    chk(magnitude == 0, "abort_mag", magnitude, 0);
    chk(phase == 0, "abort_ph", phase, 0);
    chk(in_ready == 1'b1, "abort_ready", in_ready, 1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk(in_ready == 1'b1, "post_rst_ready", in_ready, 1);
    directed("after_rst", 8192, 8192, 0, M3, T3, 64'h2000_0000);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
